// File: rtl/cpu_pkg.sv
// cpu_pkg: shared types and constants for the MiniMicro CPU sequencer.
//
// Contents:
//   INSTR_W and field positions/widths of the 28-bit instruction word
//     [27:23] opcode, [22:14] dest, [13:9] src1, [8:0] src2
//   op_e        - opcode enumeration (1..25, HLT = 25)
//   seq_state_e - sequencer FSM states
//   RESERVED_OP - true for opcodes with no defined behaviour (0, 26..31)
package cpu_pkg;

  localparam int INSTR_W  = 28;
  localparam int OP_W     = 5;
  localparam int OP_LSB   = 23;
  localparam int DEST_W   = 9;
  localparam int DEST_LSB = 14;
  localparam int SRC1_W   = 5;
  localparam int SRC1_LSB = 9;
  localparam int SRC2_W   = 9;
  localparam int SRC2_LSB = 0;

  // Width of every operand field presented to the datapath.
  localparam int FIELD_W  = 9;

  // Opcodes 1..18 are the ALU class; only ADDS has a fixed mnemonic here,
  // the rest are named by number.
  typedef enum logic [OP_W-1:0] {
    OP_ALU01 = 5'd1,
    OP_ALU02 = 5'd2,
    OP_ALU03 = 5'd3,
    OP_ALU04 = 5'd4,
    OP_ALU05 = 5'd5,
    OP_ADDS  = 5'd6,
    OP_ALU07 = 5'd7,
    OP_ALU08 = 5'd8,
    OP_ALU09 = 5'd9,
    OP_ALU10 = 5'd10,
    OP_ALU11 = 5'd11,
    OP_ALU12 = 5'd12,
    OP_ALU13 = 5'd13,
    OP_ALU14 = 5'd14,
    OP_ALU15 = 5'd15,
    OP_ALU16 = 5'd16,
    OP_ALU17 = 5'd17,
    OP_ALU18 = 5'd18,
    OP_NOP   = 5'd19,
    OP_LOADI = 5'd20,
    OP_STORE = 5'd21,
    OP_MOV   = 5'd22,
    OP_J     = 5'd23,
    OP_BEQ   = 5'd24,
    OP_HLT   = 5'd25
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALT
  } seq_state_e;

  // Opcode 0 and everything above HLT is reserved.
  function automatic logic RESERVED_OP(input logic [OP_W-1:0] op);
    return (op == 5'd0) || (op > OP_HLT);
  endfunction

endpackage

// File: rtl/cpu_decoder.sv
// cpu_decoder: purely combinational opcode classification.
//
// Ports:
//   opcode_i      in  5  opcode field of the current instruction
//   is_alu_o      out 1  ALU class (1..18)
//   needs_exec_o  out 1  instruction needs a datapath execute strobe
//                        (ALU, LOADI, STORE, MOV, BEQ)
//   is_jump_o     out 1  J
//   is_branch_o   out 1  BEQ
//   is_halt_o     out 1  HLT
//   is_illegal_o  out 1  reserved opcode
// An opcode with none of the control-flow/exec bits set is a NOP.
module cpu_decoder
  import cpu_pkg::*;
(
  input  logic [OP_W-1:0] opcode_i,
  output logic            is_alu_o,
  output logic            needs_exec_o,
  output logic            is_jump_o,
  output logic            is_branch_o,
  output logic            is_halt_o,
  output logic            is_illegal_o
);

  // Classification is a set of range/equality tests on the opcode.
  always_comb begin
    is_alu_o     = (opcode_i >= OP_ALU01) && (opcode_i <= OP_ALU18);
    is_jump_o    = (opcode_i == OP_J);
    is_branch_o  = (opcode_i == OP_BEQ);
    is_halt_o    = (opcode_i == OP_HLT);
    is_illegal_o = RESERVED_OP(opcode_i);
    needs_exec_o = is_alu_o
                || (opcode_i == OP_LOADI)
                || (opcode_i == OP_STORE)
                || (opcode_i == OP_MOV)
                || (opcode_i == OP_BEQ);
  end

endmodule

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute controller for the MiniMicro CPU.
//
// Fetches 28-bit words from instruction memory, registers the decoded
// fields towards the datapath, strobes execution and waits for completion,
// and resolves J / BEQ / HLT. Owns the program counter.
//
// Parameters: PC_W (<= 9), RESET_PC, TIMEOUT_CYC (watchdog build only).
// Ports:
//   clk_i, rst_i (async, active high), run_i (start, IDLE/HALT only)
//   imem_addr_o, imem_req_o, imem_valid_i, imem_data_i  - fetch interface
//   opcode_o, destination_o, source_1_o, source_2_o,
//   is_alu_flag_o, exec_en_o, exec_done_i, eq_flag_i    - datapath interface
//   pc_o, halted_o, illegal_o (sticky), timeout_o (sticky) - status
//
// Build option: define CPU_SEQ_TIMEOUT_EN to add the WAIT watchdog; without
// it WAIT stalls until exec_done_i and timeout_o is constant 0.
module cpu_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned PC_W        = 9,
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               run_i,
  output logic [PC_W-1:0]    imem_addr_o,
  output logic               imem_req_o,
  input  logic               imem_valid_i,
  input  logic [INSTR_W-1:0] imem_data_i,
  output logic [OP_W-1:0]    opcode_o,
  output logic [FIELD_W-1:0] destination_o,
  output logic [FIELD_W-1:0] source_1_o,
  output logic [FIELD_W-1:0] source_2_o,
  output logic               is_alu_flag_o,
  output logic               exec_en_o,
  input  logic               exec_done_i,
  input  logic               eq_flag_i,
  output logic [PC_W-1:0]    pc_o,
  output logic               halted_o,
  output logic               illegal_o,
  output logic               timeout_o
);

  localparam logic [PC_W-1:0] ResetPc = PC_W'(RESET_PC);

  seq_state_e         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [OP_W-1:0]    opcode_q, opcode_d;
  logic [FIELD_W-1:0] dest_q, dest_d;
  logic [FIELD_W-1:0] src1_q, src1_d;
  logic [FIELD_W-1:0] src2_q, src2_d;
  logic               isAlu_q, isAlu_d;
  logic               execEn_q, execEn_d;
  logic               illegal_q, illegal_d;

`ifdef CPU_SEQ_TIMEOUT_EN
  // Counter holds (WAIT cycle number - 1), so it never exceeds TIMEOUT_CYC-1.
  localparam int unsigned WaitCntW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  logic [WaitCntW-1:0] waitCnt_q, waitCnt_d;
  logic                timeout_q, timeout_d;
`endif

  logic decIsAlu, decNeedsExec, decIsJump, decIsBranch, decIsHalt, decIsIllegal;

  // The instruction register is stable from the end of FETCH until the next
  // fetch completes, so one decoder serves both DECODE and EXEC/WAIT.
  cpu_decoder uDecoder (
    .opcode_i     (instr_q[OP_LSB +: OP_W]),
    .is_alu_o     (decIsAlu),
    .needs_exec_o (decNeedsExec),
    .is_jump_o    (decIsJump),
    .is_branch_o  (decIsBranch),
    .is_halt_o    (decIsHalt),
    .is_illegal_o (decIsIllegal)
  );

  // Next-state logic. Every register holds by default; exec_en is the only
  // pulse and defaults low so it lasts exactly the EXEC cycle.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    opcode_d  = opcode_q;
    dest_d    = dest_q;
    src1_d    = src1_q;
    src2_d    = src2_q;
    isAlu_d   = isAlu_q;
    execEn_d  = 1'b0;
    illegal_d = illegal_q;
`ifdef CPU_SEQ_TIMEOUT_EN
    waitCnt_d = waitCnt_q;
    timeout_d = timeout_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (run_i) begin
          state_d = S_FETCH;
        end
      end

      S_FETCH: begin
        if (imem_valid_i) begin
          instr_d = imem_data_i;
          state_d = S_DECODE;
        end
      end

      // Fields are registered here and the strobe is armed so that it is
      // visible during EXEC.
      S_DECODE: begin
        opcode_d = instr_q[OP_LSB +: OP_W];
        dest_d   = instr_q[DEST_LSB +: DEST_W];
        src1_d   = FIELD_W'(instr_q[SRC1_LSB +: SRC1_W]);
        src2_d   = instr_q[SRC2_LSB +: SRC2_W];
        isAlu_d  = decIsAlu;
        execEn_d = decNeedsExec;
        state_d  = S_EXEC;
      end

      S_EXEC: begin
        if (decIsIllegal) begin
          illegal_d = 1'b1;
          state_d   = S_HALT;
        end else if (decIsHalt) begin
          state_d = S_HALT;
        end else if (decIsJump) begin
          pc_d    = dest_q[PC_W-1:0];
          state_d = S_FETCH;
        end else if (decNeedsExec) begin
`ifdef CPU_SEQ_TIMEOUT_EN
          waitCnt_d = '0;
`endif
          state_d = S_WAIT;
        end else begin
          pc_d    = pc_q + PC_W'(1);
          state_d = S_FETCH;
        end
      end

      // Completion wins over the watchdog in the last allowed cycle.
      S_WAIT: begin
        if (exec_done_i) begin
          if (decIsBranch && eq_flag_i) begin
            pc_d = dest_q[PC_W-1:0];
          end else begin
            pc_d = pc_q + PC_W'(1);
          end
          state_d = S_FETCH;
        end
`ifdef CPU_SEQ_TIMEOUT_EN
        else if (waitCnt_q == WaitCntW'(TIMEOUT_CYC - 1)) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else begin
          waitCnt_d = waitCnt_q + WaitCntW'(1);
        end
`endif
      end

      S_HALT: begin
        if (run_i) begin
          pc_d      = ResetPc;
          illegal_d = 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
          timeout_d = 1'b0;
`endif
          state_d   = S_FETCH;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath-facing registers; reset abandons any fetch/execute.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      pc_q      <= ResetPc;
      instr_q   <= '0;
      opcode_q  <= '0;
      dest_q    <= '0;
      src1_q    <= '0;
      src2_q    <= '0;
      isAlu_q   <= 1'b0;
      execEn_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      opcode_q  <= opcode_d;
      dest_q    <= dest_d;
      src1_q    <= src1_d;
      src2_q    <= src2_d;
      isAlu_q   <= isAlu_d;
      execEn_q  <= execEn_d;
      illegal_q <= illegal_d;
    end
  end

`ifdef CPU_SEQ_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      waitCnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      waitCnt_q <= waitCnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;
`else
  assign timeout_o = 1'b0;
`endif

  assign imem_addr_o   = pc_q;
  assign pc_o          = pc_q;
  assign imem_req_o    = (state_q == S_FETCH);
  assign halted_o      = (state_q == S_HALT);
  assign opcode_o      = opcode_q;
  assign destination_o = dest_q;
  assign source_1_o    = src1_q;
  assign source_2_o    = src2_q;
  assign is_alu_flag_o = isAlu_q;
  assign exec_en_o     = execEn_q;
  assign illegal_o     = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: self-checking bench for cpu_sequencer.
// Inputs are driven and outputs sampled on the falling clock edge. The
// reference model works at instruction level: it knows only the program
// counter, the last decoded fields and the opcode classes, and predicts what
// the sequencer must show in each phase of an instruction.
module tb_cpu_sequencer;

  localparam int PcW        = 9;
  localparam int PcMod      = 512;
  localparam int TimeoutCyc = 10;

  localparam int CLS_EXEC    = 0;
  localparam int CLS_NOP     = 1;
  localparam int CLS_JUMP    = 2;
  localparam int CLS_HALT    = 3;
  localparam int CLS_ILLEGAL = 4;

  logic           clk_i = 1'b0;
  logic           rst_i = 1'b1;
  logic           run_i = 1'b0;
  logic [PcW-1:0] imem_addr_o;
  logic           imem_req_o;
  logic           imem_valid_i = 1'b0;
  logic [27:0]    imem_data_i = '0;
  logic [4:0]     opcode_o;
  logic [8:0]     destination_o;
  logic [8:0]     source_1_o;
  logic [8:0]     source_2_o;
  logic           is_alu_flag_o;
  logic           exec_en_o;
  logic           exec_done_i = 1'b0;
  logic           eq_flag_i = 1'b0;
  logic [PcW-1:0] pc_o;
  logic           halted_o;
  logic           illegal_o;
  logic           timeout_o;

  int testsRun = 0;
  int testsFailed = 0;

  // Reference model state.
  int modelPc = 0;
  int expOp = 0;
  int expDest = 0;
  int expSrc1 = 0;
  int expSrc2 = 0;
  int expAlu = 0;

  cpu_sequencer #(
    .PC_W        (PcW),
    .RESET_PC    (0),
    .TIMEOUT_CYC (TimeoutCyc)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .run_i         (run_i),
    .imem_addr_o   (imem_addr_o),
    .imem_req_o    (imem_req_o),
    .imem_valid_i  (imem_valid_i),
    .imem_data_i   (imem_data_i),
    .opcode_o      (opcode_o),
    .destination_o (destination_o),
    .source_1_o    (source_1_o),
    .source_2_o    (source_2_o),
    .is_alu_flag_o (is_alu_flag_o),
    .exec_en_o     (exec_en_o),
    .exec_done_i   (exec_done_i),
    .eq_flag_i     (eq_flag_i),
    .pc_o          (pc_o),
    .halted_o      (halted_o),
    .illegal_o     (illegal_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  function automatic int opClass(input int op);
    if (op >= 1 && op <= 18) return CLS_EXEC;
    if (op == 20 || op == 21 || op == 22 || op == 24) return CLS_EXEC;
    if (op == 19) return CLS_NOP;
    if (op == 23) return CLS_JUMP;
    if (op == 25) return CLS_HALT;
    return CLS_ILLEGAL;
  endfunction

  task automatic checkResetValues(input string tag);
    checkOutput({tag, ".addr"}, imem_addr_o, 0);
    checkOutput({tag, ".pc"}, pc_o, 0);
    checkOutput({tag, ".opcode"}, opcode_o, 0);
    checkOutput({tag, ".dest"}, destination_o, 0);
    checkOutput({tag, ".src1"}, source_1_o, 0);
    checkOutput({tag, ".src2"}, source_2_o, 0);
    checkOutput({tag, ".req"}, imem_req_o, 0);
    checkOutput({tag, ".alu"}, is_alu_flag_o, 0);
    checkOutput({tag, ".execEn"}, exec_en_o, 0);
    checkOutput({tag, ".halted"}, halted_o, 0);
    checkOutput({tag, ".illegal"}, illegal_o, 0);
    checkOutput({tag, ".timeout"}, timeout_o, 0);
  endtask

  task automatic startRun();
    run_i = 1'b0;
    tick();
    checkOutput("idleReq", imem_req_o, 0);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
  endtask

  // Called with the DUT in HALT; holds one cycle, then restarts.
  task automatic doRestart(input logic expIllegal, input logic expTimeout);
    checkOutput("haltFlag", halted_o, 1);
    checkOutput("haltIllegal", illegal_o, expIllegal);
    checkOutput("haltTimeout", timeout_o, expTimeout);
    checkOutput("haltReq", imem_req_o, 0);
    checkOutput("haltExecEn", exec_en_o, 0);
    run_i = 1'b0;
    exec_done_i = ($urandom_range(0, 1) == 1);
    imem_valid_i = ($urandom_range(0, 1) == 1);
    tick();
    checkOutput("haltHold", halted_o, 1);
    checkOutput("illegalSticky", illegal_o, expIllegal);
    run_i = 1'b1;
    tick();
    run_i = 1'b0;
    exec_done_i = 1'b0;
    imem_valid_i = 1'b0;
    modelPc = 0;
    checkOutput("restartHalted", halted_o, 0);
    checkOutput("restartIllegal", illegal_o, 0);
    checkOutput("restartTimeout", timeout_o, 0);
  endtask

  // Runs one instruction starting from the first FETCH cycle. stall = cycles
  // without imem_valid, doneDelay = WAIT cycles before exec_done, resetAt =
  // WAIT cycle in which reset is applied (0 = never).
  task automatic applyStimulus(input logic [27:0] word, input int stall, input int doneDelay,
                               input logic eqIn, input int resetAt);
    int op;
    int cls;
    int nWait;
    logic expectTimeout;
    op = int'(word[27:23]);
    cls = opClass(op);

    checkOutput("fetchReq", imem_req_o, 1);
    checkOutput("fetchAddr", imem_addr_o, modelPc);
    checkOutput("pcOut", pc_o, modelPc);
    for (int i = 0; i < stall; i++) begin
      imem_valid_i = 1'b0;
      imem_data_i = 28'($urandom);
      exec_done_i = ($urandom_range(0, 1) == 1);
      run_i = ($urandom_range(0, 1) == 1);
      tick();
      checkOutput("stallReq", imem_req_o, 1);
      checkOutput("stallAddr", imem_addr_o, modelPc);
      checkOutput("stallOp", opcode_o, expOp);
      checkOutput("stallDest", destination_o, expDest);
    end
    imem_valid_i = 1'b1;
    imem_data_i = word;
    tick();
    imem_valid_i = ($urandom_range(0, 1) == 1);
    imem_data_i = 28'($urandom);
    exec_done_i = ($urandom_range(0, 1) == 1);
    run_i = ($urandom_range(0, 1) == 1);
    checkOutput("decodeReq", imem_req_o, 0);
    checkOutput("decodeExecEn", exec_en_o, 0);
    tick();

    expOp = op;
    expDest = int'(word[22:14]);
    expSrc1 = int'(word[13:9]);
    expSrc2 = int'(word[8:0]);
    expAlu = (op >= 1 && op <= 18) ? 1 : 0;
    checkOutput("fieldOp", opcode_o, expOp);
    checkOutput("fieldDest", destination_o, expDest);
    checkOutput("fieldSrc1", source_1_o, expSrc1);
    checkOutput("fieldSrc2", source_2_o, expSrc2);
    checkOutput("fieldAlu", is_alu_flag_o, expAlu);
    checkOutput("execEn", exec_en_o, (cls == CLS_EXEC) ? 1 : 0);
    // exec_done together with exec_en must be ignored.
    exec_done_i = ($urandom_range(0, 1) == 1);
    eq_flag_i = ($urandom_range(0, 1) == 1);
    tick();

    if (cls == CLS_EXEC) begin
      checkOutput("strobeLen", exec_en_o, 0);
      expectTimeout = 1'b0;
`ifdef CPU_SEQ_TIMEOUT_EN
      if (doneDelay + 1 > TimeoutCyc) expectTimeout = 1'b1;
`endif
      nWait = expectTimeout ? TimeoutCyc : doneDelay + 1;
      for (int c = 1; c <= nWait; c++) begin
        checkOutput("waitHalted", halted_o, 0);
        checkOutput("waitReq", imem_req_o, 0);
        imem_valid_i = ($urandom_range(0, 1) == 1);
        run_i = ($urandom_range(0, 1) == 1);
        if (c == resetAt) begin
          #2;
          rst_i = 1'b1;
          #1;
          checkResetValues("midWaitReset");
          tick();
          rst_i = 1'b0;
          exec_done_i = 1'b0;
          imem_valid_i = 1'b0;
          run_i = 1'b0;
          modelPc = 0;
          expOp = 0;
          expDest = 0;
          expSrc1 = 0;
          expSrc2 = 0;
          expAlu = 0;
          return;
        end
        if (!expectTimeout && c == nWait) begin
          exec_done_i = 1'b1;
          eq_flag_i = eqIn;
        end else begin
          exec_done_i = 1'b0;
          eq_flag_i = ($urandom_range(0, 1) == 1);
        end
        tick();
      end
      exec_done_i = 1'b0;
      if (expectTimeout) begin
        doRestart(1'b0, 1'b1);
      end else if (op == 24 && eqIn) begin
        modelPc = expDest % PcMod;
      end else begin
        modelPc = (modelPc + 1) % PcMod;
      end
    end else if (cls == CLS_NOP) begin
      modelPc = (modelPc + 1) % PcMod;
    end else if (cls == CLS_JUMP) begin
      modelPc = expDest % PcMod;
    end else if (cls == CLS_HALT) begin
      doRestart(1'b0, 1'b0);
    end else begin
      doRestart(1'b1, 1'b0);
    end
    exec_done_i = 1'b0;
    run_i = 1'b0;
  endtask

  initial begin
    int op;
    int sel;
    logic [27:0] word;

    tick();
    tick();
    checkResetValues("reset");
    rst_i = 1'b0;
    startRun();

    // ADDS dest 3 src1 1 src2 2, done in the first WAIT cycle.
    applyStimulus({5'd6, 9'd3, 5'd1, 9'd2}, 0, 0, 1'b0, 0);
    // J to 0x1F0, then to 0x1FF, NOP wraps to 0.
    applyStimulus({5'd23, 9'h1F0, 5'd0, 9'd0}, 0, 0, 1'b0, 0);
    applyStimulus({5'd23, 9'h1FF, 5'd0, 9'd0}, 0, 0, 1'b0, 0);
    applyStimulus({5'd19, 9'd0, 5'd0, 9'd0}, 1, 0, 1'b0, 0);
    // BEQ taken, then not taken from PC 5.
    applyStimulus({5'd24, 9'd40, 5'd2, 9'd7}, 0, 1, 1'b1, 0);
    applyStimulus({5'd23, 9'd5, 5'd0, 9'd0}, 0, 0, 1'b0, 0);
    applyStimulus({5'd24, 9'd40, 5'd2, 9'd7}, 0, 2, 1'b0, 0);
    // Reserved opcode halts with illegal, then restarts at 0.
    applyStimulus({5'd27, 9'd11, 5'd3, 9'd4}, 0, 0, 1'b0, 0);
    // Late imem_valid, then reset during WAIT.
    applyStimulus({5'd9, 9'd17, 5'd31, 9'd300}, 5, 4, 1'b0, 2);
    startRun();
`ifdef CPU_SEQ_TIMEOUT_EN
    applyStimulus({5'd20, 9'd1, 5'd2, 9'd3}, 0, 1000, 1'b0, 0);
    applyStimulus({5'd21, 9'd1, 5'd2, 9'd3}, 0, TimeoutCyc - 1, 1'b0, 0);
`endif

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 99);
      if (sel < 50) op = $urandom_range(1, 18);
      else if (sel < 60) op = $urandom_range(20, 22);
      else if (sel < 70) op = 24;
      else if (sel < 78) op = 19;
      else if (sel < 88) op = 23;
      else if (sel < 93) op = 25;
      else begin
        op = $urandom_range(0, 6);
        if (op != 0) op = op + 25;
      end
      word = {5'(op), 23'($urandom)};
      applyStimulus(word, $urandom_range(0, 2), $urandom_range(0, 3), ($urandom_range(0, 1) == 1), 0);
    end
    checkOutput("finalReq", imem_req_o, 1);
    checkOutput("finalAddr", imem_addr_o, modelPc);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Fetch/decode/execute controller for the MiniMicro CPU datapath. It fetches 28-bit instruction words from instruction memory, splits them into opcode/destination/source fields, drives those fields and `is_alu_flag` into the CPU/ALU datapath, and waits for execution to complete. It resolves control flow (J, BEQ, HLT) and owns the program counter.

## Interface

One clock; reset is asynchronous and active-high.

Parameters:
- `PC_W`, 9: program counter and `imem_addr` width; must be ≤ 9.
- `RESET_PC`, 0: PC value after reset and on restart.
- `TIMEOUT_CYC`, 255: WAIT-state cycle limit; only used with `CPU_SEQ_TIMEOUT_EN`.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  asynchronous active-high reset.
- `run`  in  1  start pulse; sampled in IDLE and HALT only.
- `imem_addr`  out  PC_W  fetch address, equal to PC.
- `imem_req`  out  1  fetch request, high for the whole FETCH state.
- `imem_valid`  in  1  instruction word valid; sampled only in FETCH.
- `imem_data`  in  28  instruction word: [27:23] opcode, [22:14] dest, [13:9] src1, [8:0] src2.
- `opcode`  out  5  decoded opcode.
- `destination`  out  9  dest field.
- `source_1`  out  9  src1 field, zero-extended from 5 bits.
- `source_2`  out  9  src2 field.
- `is_alu_flag`  out  1  high for ALU-class opcodes.
- `exec_en`  out  1  one-cycle execute strobe to the datapath.
- `exec_done`  in  1  datapath completion; sampled only in WAIT.
- `eq_flag`  in  1  BEQ comparison result; qualified by `exec_done`.
- `pc`  out  PC_W  current PC.
- `halted`  out  1  high in HALT.
- `illegal`  out  1  sticky; set on a reserved opcode.
- `timeout`  out  1  sticky watchdog flag.

## Operation

- States: IDLE, FETCH, DECODE, EXEC, WAIT, HALT.
- IDLE
  - `run`=1 → FETCH.
- FETCH
  - `imem_req`=1 and `imem_addr`=PC.
  - Stalls indefinitely until `imem_valid`=1.
  - On `imem_valid`, latch the word into the instruction register → DECODE.
- DECODE
  - Register the output fields from the instruction register.
  - `is_alu_flag`=1 for opcodes 1–18.
  - Output fields stay stable until the next DECODE.
- EXEC, by opcode class:
  - ALU (1–18), LOADI (20), STORE (21), MOV (22), BEQ (24): `exec_en`=1 for one cycle → WAIT.
  - NOP (19): no strobe; PC+1 → FETCH.
  - J (23): PC ← `destination[PC_W-1:0]` → FETCH.
  - HLT (25): → HALT.
  - Reserved (0, 26–31): set `illegal` → HALT.
- WAIT
  - On `exec_done`=1: for BEQ, PC ← `eq_flag` ? `destination[PC_W-1:0]` : PC+1; for all other opcodes, PC+1. Then → FETCH.
- HALT
  - `halted`=1.
  - `run` → PC ← `RESET_PC`, clear `illegal`/`timeout` → FETCH.
- Ignored inputs:
  - `run` outside IDLE/HALT.
  - `exec_done` outside WAIT.
  - `imem_valid` outside FETCH.
- PC increment wraps modulo 2^PC_W; `2^PC_W-1` + 1 → 0.
- Reset while in any state: immediately forces IDLE and all reset values. An in-flight fetch or execute is abandoned, with no completion expected.

## Timing

- Reset values:
  - PC = `imem_addr` = `pc` = `RESET_PC`.
  - `opcode`, `destination`, `source_1`, `source_2` = 0.
  - `imem_req`, `is_alu_flag`, `exec_en`, `halted`, `illegal`, `timeout` = 0.
- All outputs are registered, except `imem_req` and `halted`, which are state decodes.
- Best-case cycles per instruction, with `imem_valid` present in the first FETCH cycle:
  - `exec_done` in the first WAIT cycle: 4 (FETCH, DECODE, EXEC, WAIT).
  - J and NOP: 3.
- `exec_en` rises in the cycle after DECODE. `exec_done` counts only from the cycle after `exec_en`; asserting it in the same cycle as `exec_en` has no effect.
- The new PC appears on `imem_addr` in the first cycle of the following FETCH.

## Configuration

- `CPU_SEQ_TIMEOUT_EN` defined:
  - A WAIT-cycle counter runs, reset on each WAIT entry.
  - If `exec_done` has not arrived within `TIMEOUT_CYC` cycles, set `timeout` → HALT.
  - If `exec_done` arrives in cycle `TIMEOUT_CYC`, it completes normally.
- `CPU_SEQ_TIMEOUT_EN` undefined: WAIT stalls forever, and `timeout` is tied to 0.

## Structure

- Package `cpu_pkg`:
  - `op_e` opcode enum (values 1–25 as above, HLT=25).
  - `INSTR_W`=28 and the field position/width constants.
  - `seq_state_e`.
  - `RESERVED_OP` classification function.
- Sub-module `cpu_decoder`: combinational opcode classification, outputs `is_alu`, `needs_exec`, `is_jump`, `is_branch`, `is_halt`, `is_illegal`.
- `cpu_sequencer` holds the FSM, PC, instruction register and watchdog.

## Test plan

- Reset, then `run`. Memory: addr 0 = ADDS(6) dest 3 src1 1 src2 2; `imem_valid` immediate; `exec_done` 1 cycle after `exec_en` → `exec_en` high for exactly 1 cycle, fields 6/3/1/2, `is_alu_flag`=1, `imem_addr`=1 four cycles after the first FETCH.
- J to 0x1F0, with `PC_W`=9 → no `exec_en`; next `imem_addr`=0x1F0. NOP at 0x1FF → next `imem_addr`=0 (wrap).
- BEQ dest 40: `eq_flag`=1 with `exec_done` → `imem_addr`=40. Repeat with `eq_flag`=0 from PC 5 → `imem_addr`=6.
- Opcode 27 → `illegal`=1, `halted`=1, no `exec_en`. Then `run` → `illegal`=0, fetch from `RESET_PC`.
- Delay `imem_valid` 5 cycles, then assert `rst` mid-WAIT → `imem_req` held and fields unchanged while stalled; on `rst`, all outputs at reset values in the same cycle.
- With `CPU_SEQ_TIMEOUT_EN` and `TIMEOUT_CYC`=10, never assert `exec_done` → `timeout`=1 and HALT after 10 WAIT cycles. A second run with `exec_done` at cycle 10 → normal completion.
